boot_flash_arbiter: RTL and testbench

- Shares the single external boot-flash read port between two requesters.
  - Requester 0: the boot-stage loader engine.
  - Requester 1: the runtime host.
- Sequences fixed-latency burst reads on the port.
- Blocks host access until boot completes.
- Rejects host bursts that touch the protected bootloader region.
- Sits between the secure-boot sequencer/host and the flash pins (flash_addr / flash_read_en / flash_data).

---
 rtl/boot_flash_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_boot_flash_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_flash_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : boot_flash_arbiter
//  Description : Shares the external boot-flash read port between the
//                boot-stage loader (requester 0) and the runtime host
//                (requester 1). It sequences fixed-latency burst reads,
//                holds the host off until boot completes, and rejects host
//                bursts that touch the protected bootloader region.
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_flash_arbiter #(
    parameter int unsigned FLASH_LAT = 2,
    parameter logic [31:0] PROT_BASE = 32'h1000_0000,
    parameter logic [31:0] PROT_SIZE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_done,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic [7:0]  req0_len,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [7:0]  req1_len,
    output logic        req1_ready,
    output logic [31:0] flash_addr,
    output logic        flash_read_en,
    input  logic [31:0] flash_data,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_id,
    output logic        rd_last,
    output logic        err_valid,
    output logic        err_id,
    output logic        busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    // Protected window as a 33-bit half-open range so a window ending at
    // 2^32 is represented without wrapping.
    localparam logic [32:0] c_prot_lo = {1'b0, PROT_BASE};
    localparam logic [32:0] c_prot_hi = {1'b0, PROT_BASE} + {1'b0, PROT_SIZE};

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [31:0]          r_addr;
    logic [7:0]           r_count;
    logic                 r_id;
    logic                 r_rr_last;     // requester served most recently

    logic [FLASH_LAT-1:0] r_pipe_vld;
    logic [FLASH_LAT-1:0] r_pipe_id;
    logic [FLASH_LAT-1:0] r_pipe_last;
    logic [FLASH_LAT-1:0] w_pipe_vld_nxt;
    logic [FLASH_LAT-1:0] w_pipe_id_nxt;
    logic [FLASH_LAT-1:0] w_pipe_last_nxt;

    logic                 w_issue;
    logic                 w_issue_last;
    logic                 w_idle;
    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_win1;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic [32:0]          w_start;
    logic [32:0]          w_bytes;
    logic [32:0]          w_end;
    logic                 w_prot_hit;
    logic                 w_reject;
    logic                 w_accept;
    logic                 w_pipe_done;

    // ------------------------------------------------------------------
    // Arbitration and host-range protection (all evaluated in IDLE)
    // ------------------------------------------------------------------
    // Grants are suppressed while rst_n is low so every output reads 0
    // during reset, including the combinational ready pulses.
    assign w_idle   = (r_state == c_st_idle) & rst_n;
    assign w_elig0  = req0_valid;
    assign w_elig1  = req1_valid & boot_done;
    // With both eligible, the requester not served last wins.
    assign w_win1   = w_elig1 & (~w_elig0 | ~r_rr_last);
    assign w_gnt0   = w_idle & w_elig0 & ~w_win1;
    assign w_gnt1   = w_idle & w_win1;

    assign w_start    = {1'b0, req1_addr & 32'hFFFF_FFFC};
    assign w_bytes    = {22'd0, ({1'b0, req1_len} + 9'd1), 2'b00};
    assign w_end      = w_start + w_bytes;
    assign w_prot_hit = (w_start < c_prot_hi) & (w_end > c_prot_lo);

    assign w_reject = w_gnt1 & w_prot_hit;
    assign w_accept = (w_gnt0 | w_gnt1) & ~w_reject;

    assign w_issue      = (r_state == c_st_issue);
    assign w_issue_last = (r_count == 8'd0);
    assign w_pipe_done  = r_pipe_vld[FLASH_LAT-1] & r_pipe_last[FLASH_LAT-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant -> issue every word -> drain until last word returns
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = c_st_issue;
                end
            end
            c_st_issue: begin
                if (w_issue_last) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_pipe_done) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // FSM outputs: flash strobe, grants, rejection pulse, busy
    always_comb begin
        flash_read_en = w_issue;
        flash_addr    = w_issue ? r_addr : 32'd0;
        busy          = (r_state == c_st_issue) | (r_state == c_st_drain);
        req0_ready    = w_gnt0;
        req1_ready    = w_gnt1;
        err_valid     = w_reject;
        err_id        = w_reject;
    end

    // Burst address/count/owner capture and per-word advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= 32'd0;
            r_count <= 8'd0;
            r_id    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= w_gnt1 ? (req1_addr & 32'hFFFF_FFFC) : (req0_addr & 32'hFFFF_FFFC);
            r_count <= w_gnt1 ? req1_len : req0_len;
            r_id    <= w_gnt1;
        end else if (w_issue) begin
            r_addr  <= r_addr + 32'd4;
            r_count <= r_count - 8'd1;
        end
    end

    // Round-robin pointer; rejected host requests also count as served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= 1'b1;
        end else if (w_gnt0 | w_gnt1) begin
            r_rr_last <= w_gnt1;
        end
    end

    // ------------------------------------------------------------------
    // Latency pipe: {valid, id, last} follows each issued address
    // ------------------------------------------------------------------
    generate
        if (FLASH_LAT == 1) begin : g_lat_one
            assign w_pipe_vld_nxt  = w_issue;
            assign w_pipe_id_nxt   = r_id;
            assign w_pipe_last_nxt = w_issue_last;
        end else begin : g_lat_multi
            assign w_pipe_vld_nxt  = {r_pipe_vld[FLASH_LAT-2:0], w_issue};
            assign w_pipe_id_nxt   = {r_pipe_id[FLASH_LAT-2:0], r_id};
            assign w_pipe_last_nxt = {r_pipe_last[FLASH_LAT-2:0], w_issue_last};
        end
    endgenerate

    // Pipe shift register, flushed by reset so no stale words appear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld  <= '0;
            r_pipe_id   <= '0;
            r_pipe_last <= '0;
        end else begin
            r_pipe_vld  <= w_pipe_vld_nxt;
            r_pipe_id   <= w_pipe_id_nxt;
            r_pipe_last <= w_pipe_last_nxt;
        end
    end

    // Read data is passed straight through from the flash pins.
    assign rd_valid = r_pipe_vld[FLASH_LAT-1];
    assign rd_id    = r_pipe_vld[FLASH_LAT-1] & r_pipe_id[FLASH_LAT-1];
    assign rd_last  = r_pipe_vld[FLASH_LAT-1] & r_pipe_last[FLASH_LAT-1];
    assign rd_data  = r_pipe_vld[FLASH_LAT-1] ? flash_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_boot_flash_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_boot_flash_arbiter
//  Description : Self-checking bench for boot_flash_arbiter. A timeline model
//                schedules, per grant, which cycles carry flash addresses,
//                returned words and busy, and every cycle is compared.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_flash_arbiter;

    localparam int          LAT = 2;
    localparam logic [31:0] PB  = 32'h1000_0000;
    localparam logic [31:0] PS  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_done = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_addr = 32'd0, req1_addr = 32'd0;
    logic [7:0]  req0_len = 8'd0, req1_len = 8'd0;
    logic        req0_ready, req1_ready;
    logic [31:0] flash_addr;
    logic        flash_read_en;
    logic [31:0] flash_data = 32'd0;
    logic [31:0] rd_data;
    logic        rd_valid, rd_id, rd_last;
    logic        err_valid, err_id, busy;

    always #5 clk = ~clk;

    boot_flash_arbiter #(
        .FLASH_LAT (LAT),
        .PROT_BASE (PB),
        .PROT_SIZE (PS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .boot_done     (boot_done),
        .req0_valid    (req0_valid),
        .req0_addr     (req0_addr),
        .req0_len      (req0_len),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_addr     (req1_addr),
        .req1_len      (req1_len),
        .req1_ready    (req1_ready),
        .flash_addr    (flash_addr),
        .flash_read_en (flash_read_en),
        .flash_data    (flash_data),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_id         (rd_id),
        .rd_last       (rd_last),
        .err_valid     (err_valid),
        .err_id        (err_id),
        .busy          (busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state: cycle-indexed expectations filled in at grant time
    int          free_at = 0;   // first cycle a new grant may happen
    int          prio = 0;      // requester favoured when both are eligible
    bit [31:0]   m_fa   [int];  // cycle -> expected flash address
    bit [1:0]    m_rd   [int];  // cycle -> expected {rd_id, rd_last}
    bit          m_busy [int];
    bit          m_gnt0 = 1'b0, m_gnt1 = 1'b0;
    int          grant_q [$];
    bit [31:0]   addr_q  [$];
    int          err_cnt = 0;
    int          last_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit overlaps(input bit [31:0] a, input bit [7:0] l);
        longint s, e;
        s = longint'(a & 32'hFFFF_FFFC);
        e = s + 4 * (longint'(l) + 1);
        return (s < longint'(PB) + longint'(PS)) && (e > longint'(PB));
    endfunction

    // Reference model and per-cycle comparison
    always @(negedge clk) begin : b_model
        int        w;
        bit        xr0, xr1, xerr, xfen, xrv, xbusy;
        bit [31:0] a, xfa;
        bit [7:0]  l;
        bit [1:0]  xrd;
        m_gnt0 = 1'b0;
        m_gnt1 = 1'b0;
        if (!rst_n) begin
            m_fa.delete();
            m_rd.delete();
            m_busy.delete();
            prio    = 0;
            free_at = cyc + 1;
            check("rst req0_ready", req0_ready, 0);
            check("rst req1_ready", req1_ready, 0);
            check("rst flash_read_en", flash_read_en, 0);
            check("rst flash_addr", flash_addr, 0);
            check("rst rd_valid", rd_valid, 0);
            check("rst rd_data", rd_data, 0);
            check("rst rd_id", rd_id, 0);
            check("rst rd_last", rd_last, 0);
            check("rst err_valid", err_valid, 0);
            check("rst err_id", err_id, 0);
            check("rst busy", busy, 0);
        end else begin
            w = -1;
            xerr = 1'b0;
            if (cyc >= free_at) begin
                if (req0_valid && req1_valid && boot_done) w = prio;
                else if (req0_valid)                       w = 0;
                else if (req1_valid && boot_done)          w = 1;
            end
            xr0 = (w == 0);
            xr1 = (w == 1);
            if (w >= 0) begin
                m_gnt0 = xr0;
                m_gnt1 = xr1;
                prio   = 1 - w;
                grant_q.push_back(w);
                a = (w == 0) ? req0_addr : req1_addr;
                l = (w == 0) ? req0_len  : req1_len;
                a = a & 32'hFFFF_FFFC;
                if (w == 1 && overlaps(a, l)) begin
                    xerr = 1'b1;
                    err_cnt++;
                end else begin
                    for (int k = 0; k <= int'(l); k++) begin
                        m_fa[cyc + 1 + k] = a + 32'(4 * k);
                        addr_q.push_back(a + 32'(4 * k));
                        m_rd[cyc + 1 + k + LAT] = {w[0], (k == int'(l))};
                    end
                    for (int b = cyc + 1; b <= cyc + int'(l) + LAT + 1; b++) m_busy[b] = 1'b1;
                    free_at = cyc + int'(l) + LAT + 2;
                end
            end
            xfen  = m_fa.exists(cyc);
            xfa   = xfen ? m_fa[cyc] : 32'd0;
            xrv   = m_rd.exists(cyc);
            xrd   = xrv ? m_rd[cyc] : 2'b00;
            xbusy = m_busy.exists(cyc);
            check("req0_ready", req0_ready, xr0);
            check("req1_ready", req1_ready, xr1);
            check("err_valid", err_valid, xerr);
            if (xerr) check("err_id", err_id, 1);
            check("flash_read_en", flash_read_en, xfen);
            if (xfen) check("flash_addr", flash_addr, xfa);
            check("rd_valid", rd_valid, xrv);
            if (xrv) begin
                check("rd_id", rd_id, xrd[1]);
                check("rd_last", rd_last, xrd[0]);
                check("rd_data", rd_data, flash_data);
                if (xrd[0]) last_cnt++;
            end
            check("busy", busy, xbusy);
            if (xfen) m_fa.delete(cyc);
            if (xrv)  m_rd.delete(cyc);
            if (xbusy) m_busy.delete(cyc);
        end
        cyc++;
    end

    // Flash pins show fresh random data every cycle
    initial begin
        forever begin
            @(posedge clk);
            #2;
            flash_data = $urandom;
        end
    end

    task automatic do_req(input int id, input bit [31:0] a, input bit [7:0] l);
        int n;
        n = 0;
        @(posedge clk); #1;
        if (id == 0) begin req0_valid = 1'b1; req0_addr = a; req0_len = l; end
        else         begin req1_valid = 1'b1; req1_addr = a; req1_len = l; end
        forever begin
            @(negedge clk); #1;
            n++;
            if ((id == 0 && m_gnt0) || (id == 1 && m_gnt1)) break;
            if (n > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL grant timeout: requester %0d never granted", id);
                break;
            end
        end
        @(posedge clk); #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    function automatic bit [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return PB - 32'd64 + 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
            2:       return PB + PS - 32'd32 + 32'(4 * $urandom_range(0, 20));
            default: return 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic bit [7:0] rand_len();
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 40));
        return 8'($urandom_range(0, 7));
    endfunction

    initial begin
        int g0, e0, l0, n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single loader burst
        addr_q.delete();
        l0 = last_cnt;
        do_req(0, 32'h1000_0000, 8'd3);
        repeat (12) @(posedge clk);
        check("pin t1 words", addr_q.size(), 4);
        check("pin t1 a0", addr_q[0], 32'h1000_0000);
        check("pin t1 a1", addr_q[1], 32'h1000_0004);
        check("pin t1 a2", addr_q[2], 32'h1000_0008);
        check("pin t1 a3", addr_q[3], 32'h1000_000C);
        check("pin t1 lasts", last_cnt - l0, 1);

        // Host held off until boot completes
        g0 = grant_q.size();
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_addr = 32'h0000_2000; req1_len = 8'd0;
        repeat (50) @(posedge clk);
        check("pin t2 no grant", grant_q.size() - g0, 0);
        #1 boot_done = 1'b1;
        @(negedge clk); #1;
        check("pin t2 granted", m_gnt1, 1);
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (10) @(posedge clk);

        // Round-robin alternation with both requesters always valid
        grant_q.delete();
        l0 = last_cnt;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_addr = 32'h0000_0100; req0_len = 8'd0;
        req1_valid = 1'b1; req1_addr = 32'h0000_0200; req1_len = 8'd0;
        n = 0;
        while (grant_q.size() < 4 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) @(posedge clk);
        check("pin t3 g0", grant_q[0], 0);
        check("pin t3 g1", grant_q[1], 1);
        check("pin t3 g2", grant_q[2], 0);
        check("pin t3 g3", grant_q[3], 1);
        check("pin t3 lasts", last_cnt - l0, 4);

        // Protected-region rejection, then an adjacent legal burst
        e0 = err_cnt;
        addr_q.delete();
        do_req(1, 32'h0FFF_FFF8, 8'd3);
        repeat (3) @(posedge clk);
        check("pin t4 reject", err_cnt - e0, 1);
        check("pin t4 no words", addr_q.size(), 0);
        do_req(1, 32'h1000_1000, 8'd3);
        repeat (12) @(posedge clk);
        check("pin t4 accept a0", addr_q[0], 32'h1000_1000);
        check("pin t4 err unchanged", err_cnt - e0, 1);

        // Address wrap past 2^32
        addr_q.delete();
        do_req(0, 32'hFFFF_FFFC, 8'd1);
        repeat (10) @(posedge clk);
        check("pin t5 a0", addr_q[0], 32'hFFFF_FFFC);
        check("pin t5 a1", addr_q[1], 32'h0000_0000);

        // Reset in the middle of a long burst
        do_req(0, 32'h0000_4000, 8'd15);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        grant_q.delete();
        req0_valid = 1'b1; req0_addr = 32'h0000_5000; req0_len = 8'd1;
        req1_valid = 1'b1; req1_addr = 32'h0000_6000; req1_len = 8'd1;
        @(negedge clk); #1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n = 0;
        while (grant_q.size() < 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1 req1_valid = 1'b0;
        check("pin t6 first after reset", grant_q[0], 0);
        repeat (12) @(posedge clk);

        // Randomized traffic
        boot_done = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 199) == 0) boot_done = ~boot_done;
            if (req0_valid && m_gnt0) req0_valid = 1'b0;
            if (req1_valid && m_gnt1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1; req0_addr = rand_addr(); req0_len = rand_len();
            end else if (req0_valid && $urandom_range(0, 63) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_addr = rand_addr(); req1_len = rand_len();
            end else if (req1_valid && $urandom_range(0, 63) == 0) begin
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (60) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
